// File: rtl/programacion_parametros_if.sv
// Button, control-strobe and BCD-field bundle between the control FSM / RTC write path
// and the programacion_parametros editor.
interface programacion_parametros_if;
  logic       up_num;
  logic       down_num;
  logic       up_par;
  logic       down_par;
  logic       forma;
  logic       EN_par;
  logic       LD_par;
  logic       rst_par;
  logic       rst_Listo;
  logic [7:0] a;
  logic [7:0] me;
  logic [7:0] d;
  logic [7:0] h;
  logic [7:0] m;
  logic [7:0] s;
  logic [7:0] ht;
  logic [7:0] mt;
  logic [7:0] st;
  logic [3:0] sel;
  logic       Listo_ht;

  modport master (
    output up_num, down_num, up_par, down_par, forma, EN_par, LD_par, rst_par, rst_Listo,
    input  a, me, d, h, m, s, ht, mt, st, sel, Listo_ht
  );

  modport slave (
    input  up_num, down_num, up_par, down_par, forma, EN_par, LD_par, rst_par, rst_Listo,
    output a, me, d, h, m, s, ht, mt, st, sel, Listo_ht
  );
endinterface

// File: rtl/programacion_parametros.sv
// Debounced button-driven editor for nine BCD date/time/timer fields feeding the RTC.
// Optional feature: define AUTOREPEAT_EN for auto-repeat of held up_num/down_num.
module programacion_parametros #(
  parameter int DEB_CYCLES    = 100000,
  parameter int REPEAT_CYCLES = 2500000
) (
  input logic                      clk,
  input logic                      rst,
  programacion_parametros_if.slave bus
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // Illegal settings leave this block empty; it only anchors the parameter sanity range.
  if (DEB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_range
  end

  function automatic logic [7:0] field_lo(input logic [3:0] idx, input logic forma);
    case (idx)
      4'd1, 4'd2: return 8'h01;
      4'd3:       return forma ? 8'h01 : 8'h00;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] field_hi(input logic [3:0] idx, input logic forma);
    case (idx)
      4'd0:    return 8'h99;
      4'd1:    return 8'h12;
      4'd2:    return 8'h31;
      4'd3:    return forma ? 8'h12 : 8'h23;
      4'd6:    return 8'h23;
      default: return 8'h59;
    endcase
  endfunction

  function automatic logic [7:0] reset_val(input int idx);
    return (idx == 1 || idx == 2) ? 8'h01 : 8'h00;
  endfunction

  // Out-of-range values (stale 24 h hours in 12 h mode) land on the minimum.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v >= hi || v < lo)   return lo;
    else if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v <= lo || v > hi)    return hi;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'h9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [3:0]       raw;
  logic [3:0]       sync_p0, sync_p1;
  logic [3:0]       deb_p2;
  logic [CNT_W-1:0] cnt_p2 [4];
  logic [3:0]       deb_d_p3, ev_p3;
  logic [1:0]       num_ev;

  assign raw = {bus.down_par, bus.up_par, bus.down_num, bus.up_num};

  // Stage 0/1: two-flop synchronizer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: debounce, the counter restarts whenever the level falls back to the accepted one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_p2 <= '0;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] != deb_p2[i]) begin
          if (cnt_p2[i] == CNT_MAX) begin
            deb_p2[i] <= sync_p1[i];
            cnt_p2[i] <= '0;
          end else begin
            cnt_p2[i] <= cnt_p2[i] + 1'b1;
          end
        end else begin
          cnt_p2[i] <= '0;
        end
      end
    end
  end

  // Stage 3: rising-edge event pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_d_p3 <= '0;
      ev_p3    <= '0;
    end else begin
      deb_d_p3 <= deb_p2;
      ev_p3    <= deb_p2 & ~deb_d_p3;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_p3 [2];
  logic [1:0]       rep_p3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_p3 <= '0;
      for (int i = 0; i < 2; i++) rep_cnt_p3[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (deb_p2[i] && deb_d_p3[i] && bus.EN_par) begin
          if (rep_cnt_p3[i] == REP_MAX) begin
            rep_cnt_p3[i] <= '0;
            rep_p3[i]     <= 1'b1;
          end else begin
            rep_cnt_p3[i] <= rep_cnt_p3[i] + 1'b1;
            rep_p3[i]     <= 1'b0;
          end
        end else begin
          rep_cnt_p3[i] <= '0;
          rep_p3[i]     <= 1'b0;
        end
      end
    end
  end

  assign num_ev = ev_p3[1:0] | rep_p3;
`else
  assign num_ev = ev_p3[1:0];
`endif

  logic [7:0] fld_p4 [9];
  logic [3:0] sel_p4;
  logic       listo_p4;
  logic       up_n, dn_n, up_p, dn_p;
  logic [7:0] cur, lo, hi;

  assign up_n = bus.EN_par & num_ev[0] & ~num_ev[1];
  assign dn_n = bus.EN_par & num_ev[1] & ~num_ev[0];
  assign up_p = bus.EN_par & ev_p3[2] & ~ev_p3[3];
  assign dn_p = bus.EN_par & ev_p3[3] & ~ev_p3[2];
  assign cur  = fld_p4[sel_p4];
  assign lo   = field_lo(sel_p4, bus.forma);
  assign hi   = field_hi(sel_p4, bus.forma);

  // Stage 4: field registers, selector and completion flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) fld_p4[i] <= reset_val(i);
      sel_p4   <= '0;
      listo_p4 <= 1'b0;
    end else if (bus.rst_par) begin
      for (int i = 0; i < 9; i++) fld_p4[i] <= reset_val(i);
      sel_p4   <= '0;
      listo_p4 <= 1'b0;
    end else if (bus.LD_par) begin
      sel_p4 <= 4'd6;
    end else if (bus.rst_Listo) begin
      listo_p4 <= 1'b0;
    end else begin
      if (up_n)      fld_p4[sel_p4] <= bcd_inc(cur, lo, hi);
      else if (dn_n) fld_p4[sel_p4] <= bcd_dec(cur, lo, hi);
      if (up_p) begin
        sel_p4 <= (sel_p4 == 4'd8) ? 4'd0 : sel_p4 + 4'd1;
        if (sel_p4 == 4'd8) listo_p4 <= 1'b1;
      end else if (dn_p) begin
        sel_p4 <= (sel_p4 == 4'd0) ? 4'd8 : sel_p4 - 4'd1;
      end
    end
  end

  assign bus.a        = fld_p4[0];
  assign bus.me       = fld_p4[1];
  assign bus.d        = fld_p4[2];
  assign bus.h        = fld_p4[3];
  assign bus.m        = fld_p4[4];
  assign bus.s        = fld_p4[5];
  assign bus.ht       = fld_p4[6];
  assign bus.mt       = fld_p4[7];
  assign bus.st       = fld_p4[8];
  assign bus.sel      = sel_p4;
  assign bus.Listo_ht = listo_p4;

endmodule

// File: tb/tb_programacion_parametros.sv
// Randomized self-checking bench for programacion_parametros against a decimal field model.
module tb_programacion_parametros;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  programacion_parametros_if bus ();

  programacion_parametros #(.DEB_CYCLES(4), .REPEAT_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain decimal values with range rules
  int mf [9];
  int msel;
  bit mlisto;
  bit mforma;
  bit men;

  function automatic int mlo(input int i);
    if (i == 1 || i == 2) return 1;
    if (i == 3)           return mforma ? 1 : 0;
    return 0;
  endfunction

  function automatic int mhi(input int i);
    case (i)
      0:       return 99;
      1:       return 12;
      2:       return 31;
      3:       return mforma ? 12 : 23;
      6:       return 23;
      default: return 59;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mf[i] = (i == 1 || i == 2) ? 1 : 0;
    msel   = 0;
    mlisto = 0;
  endtask

  // mask bits: 0 up_num, 1 down_num, 2 up_par, 3 down_par
  task automatic model_apply(input logic [3:0] mask);
    int old_sel;
    if (!men) return;
    old_sel = msel;
    if (mask[0] && !mask[1]) begin
      if (mf[old_sel] >= mhi(old_sel) || mf[old_sel] < mlo(old_sel)) mf[old_sel] = mlo(old_sel);
      else mf[old_sel] = mf[old_sel] + 1;
    end else if (mask[1] && !mask[0]) begin
      if (mf[old_sel] <= mlo(old_sel) || mf[old_sel] > mhi(old_sel)) mf[old_sel] = mhi(old_sel);
      else mf[old_sel] = mf[old_sel] - 1;
    end
    if (mask[2] && !mask[3]) begin
      if (old_sel == 8) mlisto = 1;
      msel = (old_sel + 1) % 9;
    end else if (mask[3] && !mask[2]) begin
      msel = (old_sel + 8) % 9;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] g [9];
    g = '{bus.a, bus.me, bus.d, bus.h, bus.m, bus.s, bus.ht, bus.mt, bus.st};
    for (int i = 0; i < 9; i++) check($sformatf("%s_f%0d", tag, i), 32'(g[i]), 32'(to_bcd(mf[i])));
    check({tag, "_sel"}, 32'(bus.sel), 32'(msel));
    check({tag, "_listo"}, 32'(bus.Listo_ht), 32'(mlisto));
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input bit counts, input string tag);
    @(negedge clk);
    bus.forma  = mforma;
    bus.EN_par = men;
    @(negedge clk);
    {bus.down_par, bus.up_par, bus.down_num, bus.up_num} = mask;
    repeat (hold) @(negedge clk);
    {bus.down_par, bus.up_par, bus.down_num, bus.up_num} = 4'b0000;
    repeat (10) @(negedge clk);
    if (counts) model_apply(mask);
    check_all(tag);
  endtask

  // which: 0 LD_par, 1 rst_Listo, 2 rst_par
  task automatic pulse_ctl(input int which);
    @(negedge clk);
    case (which)
      0:       bus.LD_par    = 1'b1;
      1:       bus.rst_Listo = 1'b1;
      default: bus.rst_par   = 1'b1;
    endcase
    @(negedge clk);
    bus.LD_par    = 1'b0;
    bus.rst_Listo = 1'b0;
    bus.rst_par   = 1'b0;
    case (which)
      0:       msel = 6;
      1:       mlisto = 0;
      default: model_reset();
    endcase
    check_all($sformatf("ctl%0d", which));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    {bus.down_par, bus.up_par, bus.down_num, bus.up_num} = 4'b0000;
    bus.forma     = 1'b0;
    bus.EN_par    = 1'b1;
    bus.LD_par    = 1'b0;
    bus.rst_par   = 1'b0;
    bus.rst_Listo = 1'b0;
    mforma = 0;
    men    = 1;
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: raw edge to a update is exactly 8 clocks
    bus.up_num = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("lat_before", 32'(bus.a), 32'h00);
    @(posedge clk);
    #1 check("lat_after", 32'(bus.a), 32'h01);
    repeat (20) @(negedge clk);
    check("hold_no_repeat", 32'(bus.a), 32'h01);
    bus.up_num = 1'b0;
    repeat (10) @(negedge clk);
    mf[0] = 1;
    check_all("lat");

    // Minute and month wraps
    repeat (4) press(4'b0100, 12, 1, "to_sel4");
    press(4'b0010, 12, 1, "m_dn");
    check("m_wrap_dn", 32'(bus.m), 32'h59);
    press(4'b0001, 12, 1, "m_up");
    check("m_wrap_up", 32'(bus.m), 32'h00);
    repeat (3) press(4'b1000, 12, 1, "to_sel1");
    press(4'b0010, 12, 1, "me_dn");
    check("me_wrap_dn", 32'(bus.me), 32'h12);

    // Hour format handling
    repeat (2) press(4'b0100, 12, 1, "to_sel3");
    mforma = 1;
    press(4'b0001, 12, 1, "h12_from00");
    check("h12_from00_v", 32'(bus.h), 32'h01);
    press(4'b0010, 12, 1, "h12_dn");
    press(4'b0001, 12, 1, "h12_from12");
    check("h12_from12_v", 32'(bus.h), 32'h01);
    mforma = 0;
    press(4'b0010, 12, 1, "h24_dn1");
    press(4'b0010, 12, 1, "h24_dn2");
    check("h24_23", 32'(bus.h), 32'h23);
    press(4'b0001, 12, 1, "h24_wrap");
    check("h24_wrap_v", 32'(bus.h), 32'h00);
    repeat (9) press(4'b0001, 12, 1, "h24_to9");
    press(4'b0001, 12, 1, "h24_carry");
    check("h24_carry_v", 32'(bus.h), 32'h10);

    // Selector load and completion flag
    pulse_ctl(0);
    repeat (3) press(4'b0100, 12, 1, "to_listo");
    check("listo_set", 32'(bus.Listo_ht), 32'h1);
    pulse_ctl(1);

    // Glitch, simultaneous num buttons, disabled editing
    press(4'b0010, 3, 0, "glitch");
    press(4'b0011, 12, 1, "both_num");
    men = 0;
    press(4'b0001, 12, 1, "en_low");
    men = 1;

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)      pulse_ctl(0);
      else if (r == 1) pulse_ctl(1);
      else begin
        men = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0) mforma = ~mforma;
        press(4'($urandom_range(1, 15)), 12, 1, "rnd");
      end
    end
    men = 1;

    pulse_ctl(2);

    // Reset in the middle of a debounce, button still held afterwards
    @(negedge clk);
    bus.EN_par = 1'b1;
    bus.up_num = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1 model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_held_event", 32'(bus.a), 32'h01);
    bus.up_num = 1'b0;
    repeat (10) @(negedge clk);
    model_apply(4'b0001);
    check_all("rst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
